// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command codes, sequencer state encoding and mode-word field positions
//   Used by the init sequencer and the main SDRAM controller.
package sdram_pkg;
    // Command codes, bit order {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    // Mode-word field positions
    localparam int MODE_BL_LSB  = 0;
    localparam int MODE_BL_W    = 3;
    localparam int MODE_BT_BIT  = 3;
    localparam int MODE_CAS_LSB = 4;
    localparam int MODE_CAS_W   = 3;
    localparam int MODE_WB_BIT  = 9;
    // A10 selects "all banks" on PRECHARGE
    localparam int A10_BIT = 10;
    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_PWR,
        S_PRE,
        S_W_RP,
        S_REF,
        S_W_RFC,
        S_LMR,
        S_W_MRD,
        S_DONE
    } state_e;
endpackage

// File: rtl/sdram_wait_cnt.sv
// sdram_wait_cnt: loadable down-counter with zero flag, shared by all sequencer wait states
//   clk_i   clock
//   rst_ni  synchronous reset, active-low
//   load_i  load val_i this edge (wins over counting)
//   val_i   load value: the wait state lasts val_i+1 cycles
//   zero_o  counter has reached zero
module sdram_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    // Saturates at zero so an unloaded counter never wraps
    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end

    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/sdram_init_seq.sv
// sdram_init_seq: SDRAM power-up init sequencer with runtime mode reload and re-init
//   iclk/ireset     clock, synchronous active-low reset
//   ireq            start/restart full init (honoured in IDLE/DONE)
//   ilmr_req/mode   reload mode register with ilmr_mode (honoured in DONE)
//   ienb            drive DRAM pins when high, else high-Z
//   ofin/obusy      device ready / sequence in progress
//   omode           mode word currently programmed
//   DRAM_*          SDRAM pins
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int BA_W       = 2,
    parameter int DQ_W       = 16,
    parameter int PWR_CYCLES = 10000,
    parameter int REF_COUNT  = 8,
    parameter int T_RP       = 2,
    parameter int T_RFC      = 7,
    parameter int T_MRD      = 2,
    parameter logic [ADDR_W-1:0] MODE_INIT = ADDR_W'(13'h220)
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              ireq,
    input  logic              ilmr_req,
    input  logic [ADDR_W-1:0] ilmr_mode,
    input  logic              ienb,
    output logic              ofin,
    output logic              obusy,
    output logic [ADDR_W-1:0] omode,
    output wire               DRAM_CLK,
    output wire               DRAM_CKE,
    output wire  [ADDR_W-1:0] DRAM_ADDR,
    output wire  [BA_W-1:0]   DRAM_BA,
    output wire               DRAM_CS_N,
    output wire               DRAM_RAS_N,
    output wire               DRAM_CAS_N,
    output wire               DRAM_WE_N,
    output wire               DRAM_LDQM,
    output wire               DRAM_UDQM,
    output wire  [DQ_W-1:0]   DRAM_DQ
);
    localparam int W_MAX = PWR_CYCLES > T_RP ? (PWR_CYCLES > T_RFC ? (PWR_CYCLES > T_MRD ? PWR_CYCLES : T_MRD)
                                                                   : (T_RFC > T_MRD ? T_RFC : T_MRD))
                                             : (T_RP > T_RFC ? (T_RP > T_MRD ? T_RP : T_MRD)
                                                             : (T_RFC > T_MRD ? T_RFC : T_MRD));
    localparam int CW = $clog2(W_MAX + 1);
    localparam int RW = $clog2(REF_COUNT + 1);
    // Load values: the counter holds a wait state for value+1 cycles; short waits skip the state
    localparam logic [CW-1:0] LD_PWR = CW'(PWR_CYCLES - 1);
    localparam logic [CW-1:0] LD_RP  = CW'(T_RP > 1 ? T_RP - 2 : 0);
    localparam logic [CW-1:0] LD_RFC = CW'(T_RFC > 1 ? T_RFC - 2 : 0);
    localparam logic [CW-1:0] LD_MRD = CW'(T_MRD > 1 ? T_MRD - 2 : 0);
    localparam logic [ADDR_W-1:0] A10 = ADDR_W'(1) << A10_BIT;

    state_e            state_q, state_d;
    logic [3:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q, mode_q, pend_q, lmr_mode_q;
    logic [BA_W-1:0]   ba_q;
    logic [RW-1:0]     rc_q;
    logic              fin_q, busy_q, reload_q, ireq_q, lmr_q;
    logic              ld, zero, more;
    logic [CW-1:0]     ld_val;

    assign more = rc_q < RW'(REF_COUNT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = ireq_q ? S_WAIT_PWR : S_IDLE;
            S_WAIT_PWR: state_d = zero ? S_PRE : S_WAIT_PWR;
            S_PRE:      state_d = T_RP > 1 ? S_W_RP : (reload_q ? S_LMR : S_REF);
            S_W_RP:     state_d = !zero ? S_W_RP : (reload_q ? S_LMR : S_REF);
            S_REF:      state_d = T_RFC > 1 ? S_W_RFC : (more ? S_REF : S_LMR);
            S_W_RFC:    state_d = !zero ? S_W_RFC : (more ? S_REF : S_LMR);
            S_LMR:      state_d = T_MRD > 1 ? S_W_MRD : S_DONE;
            S_W_MRD:    state_d = zero ? S_DONE : S_W_MRD;
            S_DONE:     state_d = ireq_q ? S_WAIT_PWR : (lmr_q ? S_PRE : S_DONE);
            default:    state_d = S_IDLE;
        endcase
    end

    // Counter is loaded on the edge that enters a wait state
    assign ld = state_d != state_q && state_d inside {S_WAIT_PWR, S_W_RP, S_W_RFC, S_W_MRD};
    assign ld_val = state_d == S_WAIT_PWR ? LD_PWR :
                    state_d == S_W_RP     ? LD_RP  :
                    state_d == S_W_RFC    ? LD_RFC : LD_MRD;

    sdram_wait_cnt #(.W(CW)) u_wait (
        .clk_i  (iclk),
        .rst_ni (ireset),
        .load_i (ld),
        .val_i  (ld_val),
        .zero_o (zero)
    );

    // Requests are registered first, so the FSM acts one edge after sampling them
    always_ff @(posedge iclk) begin
        if (!ireset) begin
            state_q    <= S_IDLE;
            cmd_q      <= CMD_NOP;
            addr_q     <= '0;
            ba_q       <= '0;
            rc_q       <= '0;
            fin_q      <= 1'b0;
            busy_q     <= 1'b0;
            mode_q     <= MODE_INIT;
            pend_q     <= MODE_INIT;
            reload_q   <= 1'b0;
            ireq_q     <= 1'b0;
            lmr_q      <= 1'b0;
            lmr_mode_q <= '0;
        end else begin
            state_q    <= state_d;
            ireq_q     <= ireq && (state_q == S_IDLE || state_q == S_DONE);
            lmr_q      <= ilmr_req && state_q == S_DONE;
            lmr_mode_q <= ilmr_mode;
            cmd_q      <= state_d == S_PRE ? CMD_PRE : state_d == S_REF ? CMD_REF :
                          state_d == S_LMR ? CMD_LMR : CMD_NOP;
            addr_q     <= state_d == S_PRE ? A10 : state_d == S_LMR ? pend_q : '0;
            ba_q       <= {BA_W{state_d == S_PRE}};
            fin_q      <= state_d == S_DONE;
            busy_q     <= !(state_d == S_IDLE || state_d == S_DONE);
            rc_q       <= state_d == S_WAIT_PWR ? '0 : state_d == S_REF ? rc_q + 1'b1 : rc_q;
            if (state_d == S_WAIT_PWR) begin
                pend_q   <= MODE_INIT;
                reload_q <= 1'b0;
            end else if (state_q == S_DONE && state_d == S_PRE) begin
                pend_q   <= lmr_mode_q;
                reload_q <= 1'b1;
            end
            if (state_d == S_DONE && state_q != S_DONE) mode_q <= pend_q;
        end
    end

    assign ofin  = fin_q;
    assign obusy = busy_q;
    assign omode = mode_q;

    assign DRAM_CLK   = ienb ? ~iclk     : 1'bz;
    assign DRAM_CKE   = ienb ? 1'b1      : 1'bz;
    assign DRAM_ADDR  = ienb ? addr_q    : {ADDR_W{1'bz}};
    assign DRAM_BA    = ienb ? ba_q      : {BA_W{1'bz}};
    assign DRAM_CS_N  = ienb ? cmd_q[3]  : 1'bz;
    assign DRAM_RAS_N = ienb ? cmd_q[2]  : 1'bz;
    assign DRAM_CAS_N = ienb ? cmd_q[1]  : 1'bz;
    assign DRAM_WE_N  = ienb ? cmd_q[0]  : 1'bz;
    assign DRAM_LDQM  = ienb ? 1'b1      : 1'bz;
    assign DRAM_UDQM  = ienb ? 1'b1      : 1'bz;
    assign DRAM_DQ    = ienb ? '0        : {DQ_W{1'bz}};
endmodule
